sigmoid_activation: RTL and testbench
=====================================

Name: sigmoid_activation

Overview:
Downstream stage of the neuron accumulator. It takes the neuron's one-cycle LUT enable and its sign-magnitude 1.8.7 address, and reads the sigmoid LUT BRAM. It mirrors negative arguments, buffers the 1.4.11 activations in a small FIFO, and presents them to the next layer over a valid/ready handshake. It also counts the results of each layer and flags FIFO overruns.

Parameters:
RD_LAT, 1, BRAM read latency in cycles from po_bram_en to valid pi_bram_data (legal values 1..3).
FIFO_DEPTH, 4, output FIFO entries (power of two, minimum 2).
NUM_NEURONS, 10, results per layer before po_layer_done pulses (minimum 1).

Ports:
pi_clk  in  1  clock
pi_rst  in  1  synchronous active-high reset
pi_lut_en  in  1  one-cycle pulse from the neuron; address valid
pi_lut_addr  in  16  sign-magnitude argument: bit 15 sign, bits 14:7 saturated whole part (value ≤ 15), bits 6:0 fraction
pi_layer_start  in  1  clears the layer counter and the overflow flag
po_bram_en  out  1  LUT read enable
po_bram_addr  out  ADDR_W  LUT read address
pi_bram_data  in  16  LUT word, unsigned 1.4.11, range 0x0000..0x0800
po_valid  out  1  FIFO head valid
pi_ready  in  1  consumer accepts the head when po_valid=1
po_data  out  16  activation, two's complement 1.4.11
po_layer_done  out  1  one-cycle pulse
po_overflow  out  1  sticky; a result was dropped

Behaviour:
- Reset: every output is 0. The FIFO is emptied, the read pipeline is flushed, the counter is set to 0 and po_overflow is cleared. A reset mid-operation discards all in-flight reads; no result issued before the reset is ever delivered.
- Stage 1: pi_lut_en sampled high at cycle 0 drives po_bram_en=1 at cycle 1. po_bram_addr is registered at the same time.
  - po_bram_addr is computed from pi_lut_addr per the Optional Feature.
  - The sign bit, and a valid bit, travel with the read through a shift register of depth RD_LAT.
- The block accepts a new read every cycle; it never stalls the neuron.
- Stage 2: pi_bram_data is sampled at cycle 1+RD_LAT. The result register is loaded at cycle 2+RD_LAT.
- Stage 3: the result is pushed into the FIFO at the end of cycle 2+RD_LAT. If the FIFO was empty, po_valid rises at cycle 3+RD_LAT, i.e. cycle 4 with RD_LAT=1.
- FIFO:
  - First-word fall-through with registered outputs.
  - A pop occurs when po_valid and pi_ready are both high. po_data is held stable while po_valid=1 and pi_ready=0.
- FIFO boundary cases:
  - Full with a simultaneous pop: the push is accepted.
  - Full with no pop: the result is dropped, po_overflow is set, and the FIFO contents are unchanged.
  - Empty with a pop request: no effect.
- Layer counter:
  - Increments on each accepted push. Dropped results are not counted.
  - On the push that brings the count to NUM_NEURONS, po_layer_done pulses for one cycle and the counter wraps to 0.
  - pi_layer_start sets the counter to 0 and clears po_overflow.
  - pi_layer_start coinciding with a push: the counter becomes 1, and a drop in that same cycle still sets po_overflow.
- A pi_lut_en arriving while earlier reads are in flight is pipelined in order.

Optional Feature:
Macro SIGMOID_MIRROR_EN.
- Defined: ADDR_W=11 and po_bram_addr={pi_lut_addr[10:7], pi_lut_addr[6:0]}.
  - The LUT holds the positive half only.
  - Positive sign: po_data = lut word.
  - Negative sign: po_data = 16'h0800 - lut word, using 16-bit arithmetic. This never underflows for legal LUT words.
  - Negative zero (0x8000) maps to 0x0800 - lut[0].
- Undefined: ADDR_W=12 and po_bram_addr={pi_lut_addr[15], pi_lut_addr[10:0]}.
  - The LUT holds both halves.
  - po_data = lut word unmodified.
- In both modes, bits 14:11 of pi_lut_addr are ignored because the neuron has already saturated the whole part.

Decomposition:
- mlp_pkg holds:
  - ONE_Q411=16'h0800
  - DATA_W=16
  - the sign-magnitude field positions: SIGN_BIT=15, INT_LSB=7, FRAC_W=7
  - the act_t 16-bit typedef
- Sub-module act_fifo: synchronous FIFO with FIFO_DEPTH and act_t entries, and full/empty/push/pop ports. sigmoid_activation instantiates it.

Test Plan:
- RD_LAT=1, mirror on, lut[0]=0x0400, pi_lut_addr=0x0000 pulse at cycle 0 -> po_bram_en=1 at cycle 1 with addr 0x000; po_valid=1 at cycle 4 with po_data=0x0400.
- Mirror on, pi_lut_addr=0x8080 (-1.0), lut[0x080]=0x05D9 -> po_data=0x0227. Mirror off, same input -> po_bram_addr=0x880.
- pi_ready=0, FIFO_DEPTH=4, six results -> four stored, po_overflow=1 from the 5th result on. Draining then yields the first four in order.
- NUM_NEURONS=10, ten results with pi_ready=1 -> po_layer_done pulses once, on the 10th push. The 11th push does not pulse. pi_layer_start then resets the count.
- FIFO full, pi_ready=1 on the same cycle a result arrives -> no overflow, occupancy stays at 4, and the new result is delivered last.
- Reset asserted at cycle 2 after a cycle-0 pulse -> po_valid never rises and all outputs read 0 through the following cycle.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and field positions for the MLP activation path.
// Build option: SIGMOID_MIRROR_EN selects the half-table (mirrored) sigmoid LUT.
package mlp_pkg;

   localparam int unsigned DATA_W    = 16;
   localparam logic [15:0] ONE_Q411  = 16'h0800;

   // Sign-magnitude 1.8.7 argument layout
   localparam int unsigned SIGN_BIT  = 15;
   localparam int unsigned INT_LSB   = 7;
   localparam int unsigned FRAC_W    = 7;

   // Whole-part bits that reach the LUT; the neuron saturates the argument to <= 15
   localparam int unsigned LUT_INT_W = 4;

`ifdef SIGMOID_MIRROR_EN
   localparam int unsigned ADDR_W    = LUT_INT_W + FRAC_W;
`else
   localparam int unsigned ADDR_W    = 1 + LUT_INT_W + FRAC_W;
`endif

   typedef logic [DATA_W-1:0] act_t;

   // sigmoid(-x) = 1 - sigmoid(x) in unsigned 1.4.11; legal LUT words never exceed 1.0
   function automatic act_t mirror_act(input logic neg, input act_t word);
      return neg ? act_t'(ONE_Q411 - word) : word;
   endfunction

endpackage

// File: rtl/act_fifo.sv
// First-word fall-through activation FIFO with registered head, valid, full and empty.
// Head entry always sits in slot 0, so the output data is a plain register.
module act_fifo
   import mlp_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic pi_clk,
   input  logic pi_rst,
   input  logic push,
   input  act_t push_data,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic valid,
   output act_t data
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   act_t [DEPTH-1:0] mem_q;
   act_t [DEPTH-1:0] mem_n;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_n;
   logic             valid_q;
   logic             full_q;
   logic             empty_q;
   logic             do_pop_c;
   logic             do_push_c;

   // Next contents: pop shifts toward slot 0, push lands just past the surviving entries
   always_comb begin
      mem_n     = mem_q;
      cnt_n     = cnt_q;
      do_pop_c  = pop & valid_q;
      do_push_c = push & (~full_q | do_pop_c);
      if (do_pop_c) begin
         for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            mem_n[i] = mem_q[i+1];
         end
         cnt_n = cnt_q - CNT_W'(1);
      end
      if (do_push_c) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (CNT_W'(i) == cnt_n) begin
               mem_n[i] = push_data;
            end
         end
         cnt_n = cnt_n + CNT_W'(1);
      end
   end

   // Storage and registered status flags
   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         mem_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         mem_q   <= mem_n;
         cnt_q   <= cnt_n;
         valid_q <= (cnt_n != '0);
         full_q  <= (cnt_n == CNT_W'(DEPTH));
         empty_q <= (cnt_n == '0);
      end
   end

   assign full  = full_q;
   assign empty = empty_q;
   assign valid = valid_q;
   assign data  = mem_q[0];

endmodule

// File: rtl/sigmoid_activation.sv
// Sigmoid activation stage: LUT read pipeline, optional negative-argument mirroring,
// output FIFO with valid/ready, per-layer result counter and sticky overflow flag.
// Build option: SIGMOID_MIRROR_EN (half-table LUT, negatives computed as 1.0 - lut).
module sigmoid_activation
   import mlp_pkg::*;
#(
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned NUM_NEURONS = 10
) (
   input  logic              pi_clk,
   input  logic              pi_rst,
   input  logic              pi_lut_en,
   input  logic [15:0]       pi_lut_addr,
   input  logic              pi_layer_start,
   output logic              po_bram_en,
   output logic [ADDR_W-1:0] po_bram_addr,
   input  logic [15:0]       pi_bram_data,
   output logic              po_valid,
   input  logic              pi_ready,
   output logic [15:0]       po_data,
   output logic              po_layer_done,
   output logic              po_overflow
);

   localparam int unsigned CNT_W = $clog2(NUM_NEURONS + 1);

   logic [ADDR_W-1:0] lut_index_c;
   logic              unused_addr_bits;
   logic              bram_en_q;
   logic [ADDR_W-1:0] bram_addr_q;
   logic [RD_LAT-1:0] rd_vld_q;
   logic              res_vld_q;
   act_t              res_data_q;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_valid;
   act_t              fifo_data;
   logic              pop_c;
   logic              drop_c;
   logic              push_ok_c;
   logic [CNT_W-1:0]  layer_cnt_q;
   logic [CNT_W-1:0]  cnt_base_c;
   logic [CNT_W-1:0]  cnt_n_c;
   logic              done_n_c;
   logic              layer_done_q;
   logic              ovf_q;
   logic              ovf_n_c;

   // Whole-part bits 14:11 are already saturated away by the neuron
   assign unused_addr_bits = ^pi_lut_addr[SIGN_BIT-1:INT_LSB+LUT_INT_W];

`ifdef SIGMOID_MIRROR_EN
   logic              neg_s1_q;
   logic [RD_LAT-1:0] rd_neg_q;

   assign lut_index_c = {pi_lut_addr[INT_LSB+LUT_INT_W-1:INT_LSB], pi_lut_addr[FRAC_W-1:0]};

   // Sign of each read rides alongside its valid bit through the BRAM latency
   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         neg_s1_q <= 1'b0;
         rd_neg_q <= '0;
      end else begin
         if (pi_lut_en) begin
            neg_s1_q <= pi_lut_addr[SIGN_BIT];
         end
         rd_neg_q <= RD_LAT'({rd_neg_q, neg_s1_q});
      end
   end
`else
   assign lut_index_c = {pi_lut_addr[SIGN_BIT],
                         pi_lut_addr[INT_LSB+LUT_INT_W-1:INT_LSB],
                         pi_lut_addr[FRAC_W-1:0]};
`endif

   // Stage 1: issue the LUT read one cycle after the neuron's enable
   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         bram_en_q   <= 1'b0;
         bram_addr_q <= '0;
      end else begin
         bram_en_q <= pi_lut_en;
         if (pi_lut_en) begin
            bram_addr_q <= lut_index_c;
         end
      end
   end

   // Read-valid shift register matching the BRAM latency
   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         rd_vld_q <= '0;
      end else begin
         rd_vld_q <= RD_LAT'({rd_vld_q, bram_en_q});
      end
   end

   // Stage 2: capture the LUT word into the result register
   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         res_vld_q  <= 1'b0;
         res_data_q <= '0;
      end else begin
         res_vld_q <= rd_vld_q[RD_LAT-1];
         if (rd_vld_q[RD_LAT-1]) begin
`ifdef SIGMOID_MIRROR_EN
            res_data_q <= mirror_act(rd_neg_q[RD_LAT-1], pi_bram_data);
`else
            res_data_q <= pi_bram_data;
`endif
         end
      end
   end

   // A full FIFO still takes the result when the head leaves in the same cycle
   assign pop_c     = pi_ready & ~fifo_empty;
   assign drop_c    = res_vld_q & fifo_full & ~pop_c;
   assign push_ok_c = res_vld_q & ~drop_c;

   act_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .pi_clk    (pi_clk),
      .pi_rst    (pi_rst),
      .push      (res_vld_q),
      .push_data (res_data_q),
      .pop       (pop_c),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .valid     (fifo_valid),
      .data      (fifo_data)
   );

   // Layer counter and overflow next state; layer start acts before a same-cycle push
   always_comb begin
      cnt_base_c = pi_layer_start ? '0 : layer_cnt_q;
      cnt_n_c    = cnt_base_c;
      done_n_c   = 1'b0;
      ovf_n_c    = (pi_layer_start ? 1'b0 : ovf_q) | drop_c;
      if (push_ok_c) begin
         if (cnt_base_c == CNT_W'(NUM_NEURONS - 1)) begin
            cnt_n_c  = '0;
            done_n_c = 1'b1;
         end else begin
            cnt_n_c = cnt_base_c + CNT_W'(1);
         end
      end
   end

   // Layer bookkeeping registers
   always_ff @(posedge pi_clk) begin
      if (pi_rst) begin
         layer_cnt_q  <= '0;
         layer_done_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         layer_cnt_q  <= cnt_n_c;
         layer_done_q <= done_n_c;
         ovf_q        <= ovf_n_c;
      end
   end

   assign po_bram_en    = bram_en_q;
   assign po_bram_addr  = bram_addr_q;
   assign po_valid      = fifo_valid;
   assign po_data       = fifo_data;
   assign po_layer_done = layer_done_q;
   assign po_overflow   = ovf_q;

endmodule

// File: tb/tb_sigmoid_activation.sv
// Bench for sigmoid_activation: constant vector table, directed corner sequences and
// random traffic against a queue-based cycle model. Honours SIGMOID_MIRROR_EN.
`timescale 1ns/1ps
module tb_sigmoid_activation;

   localparam int RD_LAT = 1;
   localparam int DEPTH  = 4;
   localparam int NUM    = 10;
`ifdef SIGMOID_MIRROR_EN
   localparam int AW = 11;
`else
   localparam int AW = 12;
`endif

   logic          pi_clk;
   logic          pi_rst;
   logic          pi_lut_en;
   logic [15:0]   pi_lut_addr;
   logic          pi_layer_start;
   logic          po_bram_en;
   logic [AW-1:0] po_bram_addr;
   logic [15:0]   pi_bram_data;
   logic          po_valid;
   logic          pi_ready;
   logic [15:0]   po_data;
   logic          po_layer_done;
   logic          po_overflow;

   sigmoid_activation #(
      .RD_LAT      (RD_LAT),
      .FIFO_DEPTH  (DEPTH),
      .NUM_NEURONS (NUM)
   ) dut (
      .pi_clk         (pi_clk),
      .pi_rst         (pi_rst),
      .pi_lut_en      (pi_lut_en),
      .pi_lut_addr    (pi_lut_addr),
      .pi_layer_start (pi_layer_start),
      .po_bram_en     (po_bram_en),
      .po_bram_addr   (po_bram_addr),
      .pi_bram_data   (pi_bram_data),
      .po_valid       (po_valid),
      .pi_ready       (pi_ready),
      .po_data        (po_data),
      .po_layer_done  (po_layer_done),
      .po_overflow    (po_overflow)
   );

   initial pi_clk = 1'b0;
   always #5 pi_clk = ~pi_clk;

   // LUT BRAM: full table of 4096 words, upper half = 1.0 - lower half
   logic [15:0] lut [4096];
   logic [15:0] rd_pipe [RD_LAT];

   always @(posedge pi_clk) begin
      if (po_bram_en) rd_pipe[0] <= lut[int'(po_bram_addr)];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign pi_bram_data = rd_pipe[RD_LAT-1];

   int n_vec;
   int n_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: activation of a sign-magnitude argument from the sigmoid table
   function automatic logic [15:0] ref_act(input logic [15:0] a);
      logic [10:0] mag;
      mag = a[10:0];
`ifdef SIGMOID_MIRROR_EN
      return a[15] ? 16'(16'h0800 - lut[int'(mag)]) : lut[int'(mag)];
`else
      return lut[int'({a[15], mag})];
`endif
   endfunction

   function automatic logic [11:0] ref_addr(input logic [15:0] a);
`ifdef SIGMOID_MIRROR_EN
      return {1'b0, a[10:0]};
`else
      return {a[15], a[10:0]};
`endif
   endfunction

   // Cycle model: results land in the FIFO a fixed number of edges after the enable
   typedef struct { logic [15:0] val; int due; } pend_t;
   pend_t       pend[$];
   logic [15:0] mq[$];
   int          edge_n;
   int          m_cnt;
   bit          m_done;
   bit          m_ovf;
   bit          m_bram_en;
   logic [11:0] m_addr;

   task automatic model_edge();
      bit          pop;
      bit          arr;
      bit          acc;
      logic [15:0] v;
      if (pi_rst) begin
         mq.delete(); pend.delete();
         m_cnt = 0; m_done = 0; m_ovf = 0; m_bram_en = 0; m_addr = '0;
         edge_n++;
         return;
      end
      pop = (mq.size() != 0) && pi_ready;
      arr = 0; v = '0;
      if (pend.size() != 0 && pend[0].due == edge_n) begin
         arr = 1; v = pend[0].val; void'(pend.pop_front());
      end
      acc = arr && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(v);
      if (pi_layer_start) begin m_cnt = 0; m_ovf = 0; end
      m_done = 0;
      if (acc) begin
         m_cnt++;
         if (m_cnt == NUM) begin m_cnt = 0; m_done = 1; end
      end
      if (arr && !acc) m_ovf = 1;
      m_bram_en = pi_lut_en;
      if (pi_lut_en) begin
         m_addr = ref_addr(pi_lut_addr);
         pend.push_back('{ref_act(pi_lut_addr), edge_n + 2 + RD_LAT});
      end
      edge_n++;
   endtask

   task automatic compare_all();
      check("bram_en", 32'(po_bram_en), 32'(m_bram_en));
      if (m_bram_en) check("bram_addr", 32'(12'(po_bram_addr)), 32'(m_addr));
      check("valid", 32'(po_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("data", 32'(po_data), 32'(mq[0]));
      check("layer_done", 32'(po_layer_done), 32'(m_done));
      check("overflow", 32'(po_overflow), 32'(m_ovf));
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare mid-cycle
   task automatic step(input logic en, input logic [15:0] addr, input logic rdy,
                       input logic start, input logic rst);
      pi_lut_en = en; pi_lut_addr = addr; pi_ready = rdy;
      pi_layer_start = start; pi_rst = rst;
      @(posedge pi_clk);
      model_edge();
      @(negedge pi_clk);
      compare_all();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_bram_en"},   32'(po_bram_en), 32'h0);
      check({tag, "_bram_addr"}, 32'(po_bram_addr), 32'h0);
      check({tag, "_valid"},     32'(po_valid), 32'h0);
      check({tag, "_data"},      32'(po_data), 32'h0);
      check({tag, "_done"},      32'(po_layer_done), 32'h0);
      check({tag, "_ovf"},       32'(po_overflow), 32'h0);
   endtask

   typedef struct { logic [15:0] arg; logic [11:0] addr; logic [15:0] act; } vec_t;
   vec_t tbl [7];

   initial begin
      int          n;
      int          dn;
      logic [15:0] last;
      logic [15:0] a5;

      n_vec = 0; n_err = 0; edge_n = 0;
      m_cnt = 0; m_done = 0; m_ovf = 0; m_bram_en = 0; m_addr = '0;
      pi_rst = 1; pi_lut_en = 0; pi_lut_addr = '0; pi_ready = 0; pi_layer_start = 0;

      for (int i = 0; i < 2048; i++) lut[i] = 16'($urandom_range(0, 2048));
      lut[0] = 16'h0400; lut[1] = 16'h0800; lut[128] = 16'h05D9; lut[2047] = 16'h07FF;
      for (int i = 0; i < 2048; i++) lut[2048 + i] = 16'(16'h0800 - lut[i]);

`ifdef SIGMOID_MIRROR_EN
      tbl[0] = '{16'h0000, 12'h000, 16'h0400};
      tbl[1] = '{16'h8080, 12'h080, 16'h0227};
      tbl[2] = '{16'h8000, 12'h000, 16'h0400};
      tbl[3] = '{16'h7FFF, 12'h7FF, 16'h07FF};
      tbl[4] = '{16'hFFFF, 12'h7FF, 16'h0001};
      tbl[5] = '{16'h0080, 12'h080, 16'h05D9};
      tbl[6] = '{16'h8001, 12'h001, 16'h0000};
`else
      tbl[0] = '{16'h0000, 12'h000, 16'h0400};
      tbl[1] = '{16'h8080, 12'h880, 16'h0227};
      tbl[2] = '{16'h8000, 12'h800, 16'h0400};
      tbl[3] = '{16'h7FFF, 12'h7FF, 16'h07FF};
      tbl[4] = '{16'hFFFF, 12'hFFF, 16'h0001};
      tbl[5] = '{16'h0080, 12'h080, 16'h05D9};
      tbl[6] = '{16'h8001, 12'h801, 16'h0000};
`endif

      @(negedge pi_clk);

      // Reset state
      step(0, '0, 0, 0, 1);
      step(0, '0, 0, 0, 1);
      check_zero("reset");

      // Constant vectors: address at cycle 1, nothing at cycle 3, result at cycle 4
      for (int k = 0; k < 7; k++) begin
         step(1, tbl[k].arg, 1, 0, 0);
         check("tbl_bram_en", 32'(po_bram_en), 32'h1);
         check("tbl_addr", 32'(12'(po_bram_addr)), 32'(tbl[k].addr));
         step(0, '0, 1, 0, 0);
         step(0, '0, 1, 0, 0);
         check("tbl_latency", 32'(po_valid), 32'h0);
         step(0, '0, 1, 0, 0);
         check("tbl_valid", 32'(po_valid), 32'h1);
         check("tbl_data", 32'(po_data), 32'(tbl[k].act));
      end

      // Overflow: six results with consumer stalled, then drain
      step(0, '0, 1, 1, 0);
      for (int k = 0; k < 6; k++) step(1, 16'($urandom), 0, 0, 0);
      for (int k = 0; k < 5; k++) step(0, '0, 0, 0, 0);
      check("ovf_set", 32'(po_overflow), 32'h1);
      n = 0;
      for (int k = 0; k < 8; k++) begin
         if (po_valid) n++;
         step(0, '0, 1, 0, 0);
      end
      check("ovf_drain_count", 32'(n), 32'd4);
      check("ovf_sticky", 32'(po_overflow), 32'h1);
      step(0, '0, 1, 1, 0);
      check("ovf_cleared", 32'(po_overflow), 32'h0);

      // Layer counter: one pulse per NUM pushes, none on the next, start resets count
      dn = 0;
      for (int k = 0; k < NUM; k++) begin step(1, 16'($urandom), 1, 0, 0); dn += int'(po_layer_done); end
      for (int k = 0; k < 6; k++) begin step(0, '0, 1, 0, 0); dn += int'(po_layer_done); end
      check("layer_done_count", 32'(dn), 32'd1);
      dn = 0;
      step(1, 16'($urandom), 1, 0, 0);
      for (int k = 0; k < 6; k++) begin step(0, '0, 1, 0, 0); dn += int'(po_layer_done); end
      check("eleventh_no_done", 32'(dn), 32'd0);
      step(0, '0, 1, 1, 0);
      dn = 0;
      for (int k = 0; k < NUM; k++) begin step(1, 16'($urandom), 1, 0, 0); dn += int'(po_layer_done); end
      for (int k = 0; k < 6; k++) begin step(0, '0, 1, 0, 0); dn += int'(po_layer_done); end
      check("restart_done_count", 32'(dn), 32'd1);

      // Full FIFO with a pop on the cycle a new result arrives
      step(0, '0, 0, 1, 0);
      for (int k = 0; k < 4; k++) step(1, 16'($urandom), 0, 0, 0);
      for (int k = 0; k < 4; k++) step(0, '0, 0, 0, 0);
      a5 = 16'($urandom);
      step(1, a5, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 0);
      check("fullpop_no_ovf", 32'(po_overflow), 32'h0);
      n = 0; last = '0;
      for (int k = 0; k < 8; k++) begin
         if (po_valid) begin n++; last = po_data; end
         step(0, '0, 1, 0, 0);
      end
      check("fullpop_count", 32'(n), 32'd4);
      check("fullpop_last", 32'(last), 32'(ref_act(a5)));

      // Reset two cycles after an enable flushes the in-flight read
      step(1, 16'($urandom), 0, 0, 0);
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 0, 1);
      check_zero("midrst_a");
      step(0, '0, 0, 0, 0);
      check_zero("midrst_b");
      n = 0;
      for (int k = 0; k < 6; k++) begin step(0, '0, 0, 0, 0); n += int'(po_valid); end
      check("midrst_no_valid", 32'(n), 32'd0);

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         step(logic'($urandom_range(0, 1)), 16'($urandom), logic'(($urandom % 4) != 0),
              logic'(($urandom % 40) == 0), 0);
      end
      for (int k = 0; k < 12; k++) step(0, '0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
